// File: rtl/lenet_pkg.sv
// Shared types and image geometry for the LeNet frame source (LENET_TX_PINGPONG_EN selects banking in the top).
// Pure declarations: no latency, no flow control.
package lenet_pkg;

    localparam int LENET_IMG_COLS = 32;
    localparam int LENET_IMG_ROWS = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBLANK,
        S_HBLANK,
        S_ACTIVE,
        S_TAIL,
        S_DONE
    } lenet_state_t;

    // One code point beyond the image so that out-of-range host addresses can be expressed and rejected.
    function automatic int lenet_addr_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lenet_frame_ram.sv
// Image RAM: one synchronous write port, one synchronous read port, 1-cycle read latency.
// No backpressure; contents are never reset.
module lenet_frame_ram #(
    parameter int WD    = 1,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          i_sclk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [WD-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [WD-1:0] o_rd_data
);

    logic [WD-1:0] r_mem [DEPTH];
    logic [WD-1:0] r_rd_data;

    always_ff @(posedge i_sclk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lenet_frame_tx.sv
// Replays a host-loaded ROWS x COLS image as a vsync/hsync/valid raster; stream outputs lag state decode by 1 cycle.
// Free-running stream with no backpressure; LENET_TX_PINGPONG_EN adds a second bank so host writes never stall.
module lenet_frame_tx
    import lenet_pkg::*;
#(
    parameter int WD        = 1,
    parameter int COLS      = LENET_IMG_COLS,
    parameter int ROWS      = LENET_IMG_ROWS,
    parameter int HBLANK    = 8,
    parameter int VSYNC_LEN = 2,
    parameter int VBLANK    = 4,
    parameter int TAIL      = 16
) (
    input  logic                                i_sclk,
    input  logic                                i_rst,
    input  logic                                i_wr_en,
    input  logic [lenet_addr_w(ROWS*COLS)-1:0]  i_wr_addr,
    input  logic [WD-1:0]                       i_wr_data,
    input  logic                                i_start,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_wr_err,
    output logic                                o_vsync,
    output logic                                o_hsync,
    output logic                                o_valid,
    output logic [WD-1:0]                       o_tdata
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = lenet_addr_w(DEPTH);
    localparam int RAW   = $clog2(DEPTH);
    localparam int CW    = 16;

    generate
        if (HBLANK < 4 || COLS < 2) begin : g_bad_cfg
            $error("lenet_frame_tx: HBLANK must be >= 4 and COLS must be >= 2");
        end
    endgenerate

    lenet_state_t   r_state;
    lenet_state_t   w_state_nx;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_row;
    logic [RAW-1:0] r_rd_addr;
    logic           r_vsync;
    logic           r_hsync;
    logic           r_valid;
    logic           r_done;
    logic           r_wr_err;
    logic           w_start;
    logic           w_in_range;
    logic           w_wr_ok;
    logic           w_rd_en;
    logic [RAW-1:0] w_wr_idx;
    logic [WD-1:0]  w_rd_data;

    // The DONE output cycle still reads as busy, so a start there is refused like any other busy start.
    assign o_busy     = (r_state != S_IDLE) || r_done;
    assign w_start    = i_start && (r_state == S_IDLE) && !r_done;
    assign w_in_range = (i_wr_addr < AW'(DEPTH));
    assign w_wr_idx   = i_wr_addr[RAW-1:0];
    assign w_rd_en    = (r_state == S_ACTIVE);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nx = S_VSYNC;
            S_VSYNC:  if (r_cnt == CW'(VSYNC_LEN - 1)) w_state_nx = S_VBLANK;
            S_VBLANK: if (r_cnt == CW'(VBLANK - 1)) w_state_nx = S_HBLANK;
            S_HBLANK: if (r_cnt == CW'(HBLANK - 1)) w_state_nx = S_ACTIVE;
            S_ACTIVE: begin
                if (r_cnt == CW'(COLS - 1)) begin
                    w_state_nx = (r_row == CW'(ROWS - 1)) ? S_TAIL : S_HBLANK;
                end
            end
            S_TAIL:   if (r_cnt == CW'(TAIL - 1)) w_state_nx = S_DONE;
            S_DONE:   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // r_cnt restarts on every state change; the read address simply walks the image in raster order.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_row     <= '0;
            r_rd_addr <= '0;
        end else begin
            r_cnt <= (w_state_nx != r_state) ? '0 : r_cnt + CW'(1);
            if (r_state == S_IDLE) begin
                r_row     <= '0;
                r_rd_addr <= '0;
            end else if (r_state == S_ACTIVE) begin
                r_rd_addr <= r_rd_addr + RAW'(1);
                if (r_cnt == CW'(COLS - 1)) begin
                    r_row <= r_row + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            r_vsync  <= 1'b0;
            r_hsync  <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_vsync  <= (r_state == S_VSYNC);
            r_hsync  <= (r_state == S_HBLANK) && (r_cnt == '0);
            r_valid  <= (r_state == S_ACTIVE);
            r_done   <= (r_state == S_DONE);
            r_wr_err <= i_wr_en && !w_wr_ok;
        end
    end

`ifdef LENET_TX_PINGPONG_EN
    logic          r_bank;
    logic [WD-1:0] w_rd_data0;
    logic [WD-1:0] w_rd_data1;

    assign w_wr_ok = i_wr_en && w_in_range;

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            r_bank <= 1'b0;
        end else if (w_start) begin
            r_bank <= ~r_bank;
        end
    end

    // r_bank names the bank being streamed; the host always owns the other one.
    lenet_frame_ram #(.WD(WD), .DEPTH(DEPTH), .AW(RAW)) u_ram0 (
        .i_sclk    (i_sclk),
        .i_wr_en   (w_wr_ok && r_bank),
        .i_wr_addr (w_wr_idx),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data0)
    );

    lenet_frame_ram #(.WD(WD), .DEPTH(DEPTH), .AW(RAW)) u_ram1 (
        .i_sclk    (i_sclk),
        .i_wr_en   (w_wr_ok && !r_bank),
        .i_wr_addr (w_wr_idx),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data1)
    );

    assign w_rd_data = r_bank ? w_rd_data1 : w_rd_data0;
`else
    assign w_wr_ok = i_wr_en && w_in_range && !o_busy;

    lenet_frame_ram #(.WD(WD), .DEPTH(DEPTH), .AW(RAW)) u_ram (
        .i_sclk    (i_sclk),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (w_wr_idx),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data)
    );
`endif

    assign o_vsync  = r_vsync;
    assign o_hsync  = r_hsync;
    assign o_valid  = r_valid;
    assign o_done   = r_done;
    assign o_wr_err = r_wr_err;
    assign o_tdata  = r_valid ? w_rd_data : '0;

endmodule

// File: tb/tb_lenet_frame_tx.sv
// Directed bench for lenet_frame_tx: write-table vectors plus hand-written frame, restart, abort and bank sequences.
module tb_lenet_frame_tx;

    localparam int DEPTH     = 1024;
    localparam int FRAME_LEN = 1304;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [0:0]  wr_data;
    logic        start;
    logic        busy, done, wr_err, vsync, hsync, valid;
    logic [0:0]  tdata;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic mdl [2][DEPTH];
    int   act = 0;

    typedef struct {
        logic [10:0] addr;
        logic        d;
        logic        err;
    } wvec_t;

    wvec_t tbl [6];

    always #5 clk = ~clk;

    lenet_frame_tx dut (
        .i_sclk    (clk),
        .i_rst     (rst),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_start   (start),
        .o_busy    (busy),
        .o_done    (done),
        .o_wr_err  (wr_err),
        .o_vsync   (vsync),
        .o_hsync   (hsync),
        .o_valid   (valid),
        .o_tdata   (tdata)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int wbank();
`ifdef LENET_TX_PINGPONG_EN
        return act ^ 1;
`else
        return 0;
`endif
    endfunction

    // Called just after a negedge with the DUT idle (or pingpong); the error flag is visible one cycle later.
    task automatic host_write(input logic [10:0] a, input logic d, input logic exp_err, input string name);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        check(name, {31'd0, wr_err}, {31'd0, exp_err});
        if (!exp_err) mdl[wbank()][a[9:0]] = d;
    endtask

    task automatic run_frame(input int restart_t, input int wr_t, input int abort_t,
                             input logic same_wr, input string tag);
        int   done_t = 0, done_cnt = 0, vcnt = 0, hcnt = 0, vscnt = 0, vs_first = 0;
        int   dbad = 0, sbad = 0, hs_t = -100, run = 0, last_low = -100, pidx = 0;
        logic pv = 1'b0, busy1 = 1'b0, busy_after = 1'b1;
        check({tag, "/idle_busy"}, {31'd0, busy}, 32'd0);
        start = 1'b1;
        if (same_wr) begin
            wr_en = 1'b1; wr_addr = 11'd0; wr_data = ~mdl[wbank()][0];
            mdl[wbank()][0] = ~mdl[wbank()][0];
        end
`ifdef LENET_TX_PINGPONG_EN
        act = act ^ 1;
`endif
        for (int t = 1; t <= FRAME_LEN + 100; t++) begin
            @(negedge clk);
            if (t == 1) begin
                start = 1'b0;
                busy1 = busy;
                if (same_wr) wr_en = 1'b0;
            end
            if (restart_t > 0) start = (t >= restart_t && t < restart_t + 20);
            if (t == wr_t) begin
                wr_en = 1'b1; wr_addr = 11'd5; wr_data = ~mdl[0][5];
            end
            if (wr_t > 0 && t == wr_t + 1) begin
                wr_en = 1'b0;
                check({tag, "/busy_wr_err"}, {31'd0, wr_err}, 32'd1);
            end
            if (t == abort_t) begin
                check({tag, "/valid_before_abort"}, {31'd0, valid}, 32'd1);
                #2 rst = 1'b1;
                #1 check({tag, "/outs_in_reset"}, {25'd0, busy, done, wr_err, vsync, hsync, valid, tdata}, 32'd0);
                @(negedge clk);
                check({tag, "/done_in_reset"}, {31'd0, done}, 32'd0);
                rst = 1'b0;
                return;
            end
            if (vsync) begin
                vscnt++;
                if (vscnt == 1) vs_first = t;
            end
            if (hsync) begin
                hcnt++;
                hs_t = t;
            end
            if (valid) begin
                if (!pv) begin
                    if (t - hs_t != 8) sbad++;
                    if (t - last_low < 8) sbad++;
                end
                if (pidx >= DEPTH || tdata !== mdl[act][pidx]) dbad++;
                pidx++;
                run++;
                vcnt++;
            end else begin
                if (tdata !== 1'b0) dbad++;
                if (pv) begin
                    if (run != 32) sbad++;
                    run = 0;
                    last_low = t;
                end
            end
            pv = valid;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_t = t;
            end
            if (done_t > 0 && t == done_t + 1) begin
                busy_after = busy;
                break;
            end
        end
        check({tag, "/busy_after_start"}, {31'd0, busy1}, 32'd1);
        check({tag, "/frame_len"}, done_t, FRAME_LEN);
        check({tag, "/done_pulses"}, done_cnt, 32'd1);
        check({tag, "/valid_cycles"}, vcnt, 32'd1024);
        check({tag, "/hsync_pulses"}, hcnt, 32'd32);
        check({tag, "/vsync_cycles"}, vscnt, 32'd2);
        check({tag, "/vsync_first"}, vs_first, 32'd2);
        check({tag, "/data_errs"}, dbad, 32'd0);
        check({tag, "/spacing_errs"}, sbad, 32'd0);
        check({tag, "/busy_after_done"}, {31'd0, busy_after}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{11'd0,    1'b1, 1'b0};
        tbl[1] = '{11'd1023, 1'b1, 1'b0};
        tbl[2] = '{11'd1024, 1'b1, 1'b1};
        tbl[3] = '{11'd2047, 1'b0, 1'b1};
        tbl[4] = '{11'd40,   1'b0, 1'b0};
        tbl[5] = '{11'd1024, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #1 check("reset_outs", {25'd0, busy, done, wr_err, vsync, hsync, valid, tdata}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", {25'd0, busy, done, wr_err, vsync, hsync, valid, tdata}, 32'd0);

        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                host_write(11'(r * 32 + c), 1'((r ^ c) & 1), 1'b0, "load_wr_err");

        for (int i = 0; i < 6; i++)
            host_write(tbl[i].addr, tbl[i].d, tbl[i].err, $sformatf("tbl%0d_wr_err", i));

`ifdef LENET_TX_PINGPONG_EN
        fork
            run_frame(-1, -1, -1, 1'b0, "ppA");
            begin
                repeat (20) @(negedge clk);
                for (int i = 0; i < DEPTH; i++)
                    host_write(11'(i), 1'(((i / 32) ^ (i % 32) ^ 1) & 1), 1'b0, "pp_busy_wr_err");
            end
        join
        run_frame(-1, -1, -1, 1'b0, "ppB");
        host_write(11'd1024, 1'b1, 1'b1, "pp_range_err");
        run_frame(-1, -1, -1, 1'b1, "ppC");
`else
        run_frame(-1, -1, -1, 1'b0, "f1");
        run_frame(100, 500, -1, 1'b0, "f2_restart_wr");
        run_frame(-1, -1, -1, 1'b0, "f3_ram_kept");
        run_frame(-1, -1, 427, 1'b0, "abort");
        @(negedge clk);
        run_frame(-1, -1, -1, 1'b1, "f4_wr_start");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
